// File: rtl/pulse_burst_scheduler_pkg.sv
// Shared definitions for the pulse burst scheduler.
//   state_e : FSM state encoding (2 bits)
//   max1    : width floor, maps a zero phase width to one cycle
package pulse_burst_scheduler_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StHigh = 2'd1,
    StLow  = 2'd2,
    StDone = 2'd3
  } state_e;

  // Generic 32-bit form; callers truncate back to their field width.
  function automatic logic [31:0] max1(input logic [31:0] w);
    return (w == 32'd0) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/pulse_burst_scheduler_if.sv
// Bus bundle for the pulse burst scheduler.
//   req    : per-requester burst request (level)
//   cnt    : per-requester burst length, slice i = cnt[i*CNT_W +: CNT_W]
//   hi_w   : high-phase width in cycles (0 means 1)
//   lo_w   : low-phase width in cycles (0 means 1)
//   grant  : one-hot owner of the current burst
//   done   : one-cycle end-of-burst strobe to the owner
//   busy   : scheduler not idle
//   signal : shared pulse train
// master = requester side, slave = scheduler side.
interface pulse_burst_scheduler_if #(
  parameter int N_REQ = 2,
  parameter int CNT_W = 4,
  parameter int WID_W = 3
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*CNT_W-1:0] cnt;
  logic [WID_W-1:0]       hi_w;
  logic [WID_W-1:0]       lo_w;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic                   signal;

  modport master (
    output req, cnt, hi_w, lo_w,
    input  grant, done, busy, signal
  );

  modport slave (
    input  req, cnt, hi_w, lo_w,
    output grant, done, busy, signal
  );
endinterface

// File: rtl/pulse_burst_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector
//   ptr    : index of the last winner; scanning starts at ptr+1
//   winner : one-hot selected requester (0 if none)
//   valid  : at least one request present
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic [PW-1:0] sel;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sel    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      sel = PW'((int'(ptr) + i) % N_REQ);
      if (!valid && req[sel]) begin
        winner[sel] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pulse_burst_scheduler.sv
// Shares one pulse-train output between N_REQ requesters. A round-robin winner gets a burst
// of cnt pulses (hi_w high cycles, lo_w low cycles each), followed by a one-cycle done strobe.
//   clk   : clock, all state on posedge
//   reset : synchronous active-high reset
//   bus   : scheduler side of pulse_burst_scheduler_if (req/cnt/hi_w/lo_w in,
//           grant/done/busy/signal out)
module pulse_burst_scheduler
  import pulse_burst_scheduler_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int CNT_W = 4,
  parameter int WID_W = 3
) (
  input logic                    clk,
  input logic                    reset,
  pulse_burst_scheduler_if.slave bus
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WID_W-1:0] phase_q, phase_d;
  logic [WID_W-1:0] hw_q, hw_d;
  logic [WID_W-1:0] lw_q, lw_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             signal_q, signal_d;

  logic [N_REQ-1:0] arb_winner;
  logic             arb_valid;
  logic [CNT_W-1:0] cnt_sel;
  logic [PW-1:0]    grant_idx;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_arb (
    .req    (bus.req),
    .ptr    (ptr_q),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  always_comb begin
    cnt_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (arb_winner[i]) cnt_sel = bus.cnt[i*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) grant_idx = PW'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rem_d   = rem_q;
    phase_d = phase_q;
    hw_d    = hw_q;
    lw_d    = lw_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (arb_valid) begin
          grant_d = arb_winner;
          rem_d   = cnt_sel;
          hw_d    = WID_W'(max1(32'(bus.hi_w)));
          lw_d    = WID_W'(max1(32'(bus.lo_w)));
          phase_d = hw_d - WID_W'(1);
          // Zero-length burst skips straight to the done strobe.
          state_d = (cnt_sel != '0) ? StHigh : StDone;
        end
      end
      StHigh: begin
        if (phase_q == '0) begin
          state_d = StLow;
          phase_d = lw_q - WID_W'(1);
        end else begin
          phase_d = phase_q - WID_W'(1);
        end
      end
      StLow: begin
        if (phase_q == '0) begin
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = StDone;
          end else begin
            state_d = StHigh;
            phase_d = hw_q - WID_W'(1);
          end
        end else begin
          phase_d = phase_q - WID_W'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
        grant_d = '0;
        ptr_d   = grant_idx;
      end
      default: state_d = StIdle;
    endcase
    signal_d = (state_d == StHigh);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rem_q    <= '0;
      phase_q  <= '0;
      hw_q     <= '0;
      lw_q     <= '0;
      ptr_q    <= PW'(N_REQ - 1);
      signal_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rem_q    <= rem_d;
      phase_q  <= phase_d;
      hw_q     <= hw_d;
      lw_q     <= lw_d;
      ptr_q    <= ptr_d;
      signal_q <= signal_d;
    end
  end

  assign bus.grant  = grant_q;
  assign bus.done   = (state_q == StDone) ? grant_q : '0;
  assign bus.busy   = (state_q != StIdle);
  assign bus.signal = signal_q;

endmodule

// File: tb/tb_pulse_burst_scheduler.sv
module tb_pulse_burst_scheduler;

  localparam int N_REQ = 2;
  localparam int CNT_W = 4;
  localparam int WID_W = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  pulse_burst_scheduler_if #(.N_REQ(N_REQ), .CNT_W(CNT_W), .WID_W(WID_W)) bus ();

  pulse_burst_scheduler #(.N_REQ(N_REQ), .CNT_W(CNT_W), .WID_W(WID_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Observation word: {busy, signal, done[1:0], grant[1:0]}
  function automatic logic [5:0] obs();
    return {bus.busy, bus.signal, bus.done, bus.grant};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b1;
    bus.req = '0;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic set_in(input logic [1:0] r, input logic [3:0] c0, input logic [3:0] c1,
                        input logic [2:0] h, input logic [2:0] l);
    bus.req  = r;
    bus.cnt  = {c1, c0};
    bus.hi_w = h;
    bus.lo_w = l;
  endtask

  typedef struct {
    logic [1:0] req;
    logic [3:0] c0;
    logic [3:0] c1;
    logic [2:0] hi;
    logic [2:0] lo;
    logic [1:0] g;
    int         busy_n;
    int         high_n;
  } row_t;

  row_t rows[6];

  // Reference model state for the random phase
  logic [5:0] mq[$];
  bit         m_prev_idle;
  int         m_ptr;

  task automatic model_arb();
    int w;
    int c;
    int hw;
    int lw;
    logic [1:0] g;
    w = -1;
    for (int i = 1; i <= N_REQ; i++) begin
      int idx;
      idx = (m_ptr + i) % N_REQ;
      if (w < 0 && bus.req[idx]) w = idx;
    end
    if (w < 0) return;
    g  = 2'(1 << w);
    c  = int'(bus.cnt[w*CNT_W +: CNT_W]);
    hw = (bus.hi_w == 0) ? 1 : int'(bus.hi_w);
    lw = (bus.lo_w == 0) ? 1 : int'(bus.lo_w);
    for (int k = 0; k < c; k++) begin
      for (int j = 0; j < hw; j++) mq.push_back({2'b11, 2'b00, g});
      for (int j = 0; j < lw; j++) mq.push_back({2'b10, 2'b00, g});
    end
    mq.push_back({2'b10, g, g});
    m_ptr = w;
  endtask

  initial begin
    logic [5:0] seq[$];
    int busy_n, high_n, done_n;
    logic [1:0] done_v;
    bit saw_done;

    reset = 1'b1;
    set_in(2'b00, 4'd0, 4'd0, 3'd0, 3'd0);

    // Idle after reset with no requests
    apply_reset();
    for (int k = 0; k < 12; k++) begin
      chk("idle_after_reset", obs(), 6'h00);
      step();
    end

    // Single-burst table: grant, busy length, high count, done
    rows[0] = '{2'b01, 4'd3,  4'd0,  3'd2, 3'd1, 2'b01, 10,  6};
    rows[1] = '{2'b10, 4'd0,  4'd2,  3'd1, 3'd1, 2'b10, 5,   2};
    rows[2] = '{2'b01, 4'd0,  4'd9,  3'd3, 3'd3, 2'b01, 1,   0};
    rows[3] = '{2'b11, 4'd2,  4'd5,  3'd0, 3'd0, 2'b01, 5,   2};
    rows[4] = '{2'b10, 4'd1,  4'd15, 3'd7, 3'd7, 2'b10, 211, 105};
    rows[5] = '{2'b11, 4'd1,  4'd1,  3'd4, 3'd0, 2'b01, 6,   4};
    for (int r = 0; r < 6; r++) begin
      apply_reset();
      set_in(rows[r].req, rows[r].c0, rows[r].c1, rows[r].hi, rows[r].lo);
      step();
      chk($sformatf("row%0d_grant", r), int'(bus.grant), int'(rows[r].g));
      bus.req = 2'b00;
      busy_n = 0; high_n = 0; done_n = 0; done_v = '0;
      for (int k = 0; k < 400 && bus.busy; k++) begin
        busy_n++;
        if (bus.signal) high_n++;
        if (bus.done != 0) begin
          done_n++;
          done_v = bus.done;
        end
        step();
      end
      chk($sformatf("row%0d_busy_len", r), busy_n, rows[r].busy_n);
      chk($sformatf("row%0d_high_cnt", r), high_n, rows[r].high_n);
      chk($sformatf("row%0d_done_cnt", r), done_n, 1);
      chk($sformatf("row%0d_done_val", r), int'(done_v), int'(rows[r].g));
    end

    // Exact waveform of a 3-pulse burst
    apply_reset();
    set_in(2'b01, 4'd3, 4'd0, 3'd2, 3'd1);
    step();
    bus.req = 2'b00;
    seq = '{6'h31, 6'h31, 6'h21, 6'h31, 6'h31, 6'h21, 6'h31, 6'h31, 6'h21, 6'h25, 6'h00};
    foreach (seq[k]) begin
      chk($sformatf("wave3_c%0d", k), obs(), seq[k]);
      step();
    end

    // Both requesting: req0, then req1, then req0 again
    apply_reset();
    set_in(2'b11, 4'd1, 4'd2, 3'd1, 3'd1);
    step();
    seq = '{6'h31, 6'h21, 6'h25, 6'h00, 6'h32, 6'h22, 6'h32, 6'h22, 6'h2A, 6'h00, 6'h31};
    foreach (seq[k]) begin
      chk($sformatf("rr_c%0d", k), obs(), seq[k]);
      step();
    end
    bus.req = 2'b00;

    // Zero widths act as 1; hi_w change mid-burst ignored
    apply_reset();
    set_in(2'b01, 4'd2, 4'd0, 3'd0, 3'd0);
    step();
    bus.req  = 2'b00;
    bus.hi_w = 3'd5;
    seq = '{6'h31, 6'h21, 6'h31, 6'h21, 6'h25, 6'h00};
    foreach (seq[k]) begin
      chk($sformatf("minw_c%0d", k), obs(), seq[k]);
      step();
    end

    // Reset during the second HIGH aborts with no done
    apply_reset();
    set_in(2'b01, 4'd4, 4'd1, 3'd2, 3'd1);
    step();
    bus.req = 2'b00;
    step(); step(); step();
    chk("abort_in_2nd_high", obs(), 6'h31);
    reset = 1'b1;
    saw_done = 1'b0;
    step();
    chk("abort_outputs", obs(), 6'h00);
    step();
    if (bus.done != 0) saw_done = 1'b1;
    reset = 1'b0;
    bus.req = 2'b10;
    step();
    if (bus.done != 0) saw_done = 1'b1;
    chk("abort_no_done", int'(saw_done), 0);
    chk("abort_req1_wins", obs(), 6'h32);
    bus.req = 2'b00;
    for (int k = 0; k < 10 && bus.busy; k++) step();

    // Randomized traffic against the reference model
    apply_reset();
    mq.delete();
    m_prev_idle = 1'b1;
    m_ptr       = N_REQ - 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic [5:0] exp;
      bit         was_empty;
      bus.req  = ($urandom_range(0, 3) == 0) ? 2'(($urandom_range(0, 3))) : bus.req;
      bus.cnt  = 8'($urandom_range(0, 255));
      bus.cnt[3] = 1'b0;
      bus.cnt[7] = 1'b0;
      bus.hi_w = 3'($urandom_range(0, 7));
      bus.lo_w = 3'($urandom_range(0, 7));
      @(posedge clk);
      if (mq.size() == 0 && m_prev_idle) model_arb();
      #1;
      was_empty = (mq.size() == 0);
      exp = was_empty ? 6'h00 : mq.pop_front();
      m_prev_idle = was_empty;
      chk($sformatf("rand_c%0d", cyc), obs(), exp);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
